frogger_game_ctrl: RTL and testbench
====================================

Name: frogger_game_ctrl

Overview:
Game-level sequencer for Frogger. Runs in the Clk (50 MHz) domain and derives a one-cycle frame tick from VGA vsync. Turns raw USB keycodes into single-hop move pulses for frog. Judges car and river deaths and goal crossings, and owns lives, score, level and frog respawn. Sits between the Nios keycode export, the car/lilypad row collision outputs, frog and color_mapper.

Parameters:
NUM_LIVES, 3, lives loaded at game start (1..3)
DEATH_FRAMES, 60, frames held in DYING/LEVEL_UP before resuming
GOAL_Y, 40, Frog_Y at or above (<=) this value counts as goal reached
LEVEL_MAX, 7, level saturation value
TIME_LIMIT, 200, frames per life (FROGGER_TIMER_EN only)

Ports:
Clk  in  1  system clock, 50 MHz
Reset_n  in  1  asynchronous, active-low reset
frame_vs  in  1  raw VGA vsync, asynchronous to Clk use
keycode  in  16  USB keycode from nios_system
Car_Collision  in  4  per-row car hit, one bit per car row
LPad_Collision  in  4  per-row frog-on-lilypad flags
Frog_In_River  in  1  frog Y is inside river band
Frog_Y  in  11  frog top-left Y
up, down, left, right  out  1 each  one-Clk hop pulses to frog
Frog_Respawn  out  1  one-Clk pulse; frog returns to start
Game_Run  out  1  high only in PLAY; gates row motion
Lives  out  2  remaining lives
Score  out  8  goals reached, saturating at 255
Level  out  3  current level, drives row speed scaling
State  out  3  encoded FSM state, for color_mapper and LEDG

Behaviour:
- Frame tick: frame_vs passes through a 2-FF synchroniser. The tick is a 1-cycle pulse on the synchronised falling edge. All game evaluation happens only on tick cycles.
- Reset values:
  - State = ATTRACT
  - Lives = NUM_LIVES, Score = 0, Level = 0
  - all pulses = 0, Game_Run = 0
  - frame counter = 0, key latch = 0
- States:
  - ATTRACT = 0: on keycode == 0x28 (Enter), load Lives = NUM_LIVES, Score = 0, Level = 0, pulse Frog_Respawn, go to PLAY.
  - PLAY = 1: Game_Run = 1. On each tick:
    - Death: any Car_Collision bit set, OR (Frog_In_River AND LPad_Collision == 0) → DYING.
    - Goal (Frog_Y <= GOAL_Y) with no death → LEVEL_UP.
    - Death and goal on the same tick → death wins.
  - DYING = 2: on entry, Lives -= 1 and frame counter cleared. After DEATH_FRAMES ticks: if Lives == 0, go to GAME_OVER; else pulse Frog_Respawn and go to PLAY.
  - LEVEL_UP = 3: on entry, Score += 1 (saturate at 255) and Level += 1 (saturate at LEVEL_MAX). After DEATH_FRAMES ticks, pulse Frog_Respawn and go to PLAY.
  - GAME_OVER = 4: Score and Level are held. Enter behaves as in ATTRACT.
  - Codes 5–7 are illegal and return to ATTRACT.
- Hop generation (keycodes: left 0x50, right 0x4F, up 0x52, down 0x51):
  - A key is accepted only when the key latch is 0. The matching hop is then armed and the latch set.
  - keycode == 0 clears the latch. Held keys never repeat.
  - The armed hop issues as a 1-Clk pulse on the next tick, only while in PLAY. Otherwise it is dropped.
  - At most one hop per tick. Non-arrow keys are ignored, but they still set the latch.
- Key arriving on the same cycle as a tick: it is armed for the following tick.
- Reset asserted mid-game: immediate asynchronous return to reset values; no pulse is emitted.
- Frog_Respawn and hop pulses are never asserted in the same cycle. Respawn has priority.

Optional Feature:
FROGGER_TIMER_EN
- Defined:
  - An 8-bit per-life countdown loads TIME_LIMIT on every Frog_Respawn and decrements each PLAY tick.
  - Reaching 0 in PLAY is treated as a death, with the same priority as a collision.
  - Adds output Time_Left[7:0], which is 0 at reset.
- Undefined: no countdown logic and no Time_Left port. Death comes from collisions only.

Decomposition:
- frogger_pkg: game_state_t enum (ATTRACT..GAME_OVER, 3-bit), key constants KEY_LEFT/RIGHT/UP/DOWN/ENTER, SCORE_W = 8, LEVEL_W = 3.
- Sub-module frame_tick_gen: vsync synchroniser plus falling-edge detector; output tick. Also reusable by the row modules.

Test Plan:
- Reset_n low, then Enter (0x28), then 2 ticks → Frog_Respawn pulse once; State = 1, Lives = 3, Game_Run = 1.
- In PLAY, hold keycode 0x52 for 10 ticks, then 0, then 0x52 → exactly 2 up pulses, each coincident with a tick.
- Car_Collision = 4'b0100 at a tick → State = 2, Lives = 2. After 60 ticks: Frog_Respawn pulse, State = 1. Repeat 3 times → State = 4, Lives = 0.
- Frog_In_River = 1 with LPad_Collision = 4'b0010 → no death. Drop LPad_Collision to 0 → DYING on the next tick.
- Frog_Y = 40 and Car_Collision = 1 on the same tick → DYING, Score stays 0. Frog_Y = 40 alone → Score = 1, Level = 1. Eight goals → Level = 7.
- Reset_n pulsed low while in DYING → State = 0, Lives = 3, Score = 0 immediately. With FROGGER_TIMER_EN: 200 idle PLAY ticks → DYING.

Source files
------------

// File: rtl/frogger_pkg.sv
// Shared types and constants for the Frogger game controller and its helpers.
// Holds the game state encoding, hop encoding and USB keycode constants.
package frogger_pkg;

    localparam int SCORE_W = 8;
    localparam int LEVEL_W = 3;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {
        ATTRACT   = 3'd0,
        PLAY      = 3'd1,
        DYING     = 3'd2,
        LEVEL_UP  = 3'd3,
        GAME_OVER = 3'd4
    } game_state_t;

    typedef enum logic [2:0] {
        HOP_NONE  = 3'd0,
        HOP_UP    = 3'd1,
        HOP_DOWN  = 3'd2,
        HOP_LEFT  = 3'd3,
        HOP_RIGHT = 3'd4
    } hop_t;

    localparam logic [15:0] KEY_LEFT  = 16'h0050;
    localparam logic [15:0] KEY_RIGHT = 16'h004F;
    localparam logic [15:0] KEY_UP    = 16'h0052;
    localparam logic [15:0] KEY_DOWN  = 16'h0051;
    localparam logic [15:0] KEY_ENTER = 16'h0028;

    function automatic hop_t key_to_hop(input logic [15:0] key);
        case (key)
            KEY_UP:    return HOP_UP;
            KEY_DOWN:  return HOP_DOWN;
            KEY_LEFT:  return HOP_LEFT;
            KEY_RIGHT: return HOP_RIGHT;
            default:   return HOP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Brings raw VGA vsync into the clk domain and emits a one-cycle tick on
// its synchronised falling edge.
module frame_tick_gen (
    input  logic clk,
    input  logic rst_n,
    input  logic vs,
    output logic tick
);

    // [0] and [1] form the synchroniser; [2] is the delayed copy for edge detection.
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], vs};
        end
    end

    assign tick = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/frogger_game_ctrl.sv
// Frogger game sequencer: frame tick, hop pulses, death/goal judging, lives,
// score, level and respawn. Optional per-life countdown under FROGGER_TIMER_EN.
module frogger_game_ctrl
    import frogger_pkg::*;
#(
    parameter int unsigned NUM_LIVES    = 3,
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned GOAL_Y       = 40,
    parameter int unsigned LEVEL_MAX    = 7
`ifdef FROGGER_TIMER_EN
    , parameter int unsigned TIME_LIMIT = 200
`endif
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               frame_vs,
    input  logic [15:0]        keycode,
    input  logic [3:0]         Car_Collision,
    input  logic [3:0]         LPad_Collision,
    input  logic               Frog_In_River,
    input  logic [10:0]        Frog_Y,
    output logic               up,
    output logic               down,
    output logic               left,
    output logic               right,
    output logic               Frog_Respawn,
    output logic               Game_Run,
    output logic [1:0]         Lives,
    output logic [SCORE_W-1:0] Score,
    output logic [LEVEL_W-1:0] Level,
    output logic [2:0]         State
`ifdef FROGGER_TIMER_EN
    , output logic [7:0]       Time_Left
`endif
);

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DEATH_FRAMES - 1);
    localparam logic [1:0]         LIVES_INIT = 2'(NUM_LIVES);
    localparam logic [LEVEL_W-1:0] LEVEL_TOP  = LEVEL_W'(LEVEL_MAX);
    localparam logic [10:0]        GOAL_LINE  = 11'(GOAL_Y);

    game_state_t        state_q, state_d;
    logic [1:0]         lives_q, lives_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               latch_q, latch_d;
    hop_t               armed_q, armed_d;
    hop_t               key_hop;
    logic               tick;
    logic               respawn;
    logic               death;
    logic               goal;
    logic               time_out;
    logic               hop_fire;

    frame_tick_gen u_tick (
        .clk   (Clk),
        .rst_n (Reset_n),
        .vs    (frame_vs),
        .tick  (tick)
    );

`ifdef FROGGER_TIMER_EN
    logic [7:0] time_q, time_d;

    // A frog on its last frame of time dies on this tick, like a collision.
    assign time_out = (time_q <= 8'd1);

    always_comb begin
        time_d = time_q;
        if (respawn) begin
            time_d = 8'(TIME_LIMIT);
        end else if (tick && (state_q == PLAY) && (time_q != 8'd0)) begin
            time_d = time_q - 8'd1;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            time_q <= 8'd0;
        end else begin
            time_q <= time_d;
        end
    end

    assign Time_Left = time_q;
`else
    assign time_out = 1'b0;
`endif

    assign death = (|Car_Collision) || (Frog_In_River && (LPad_Collision == 4'd0)) || time_out;
    assign goal  = (Frog_Y <= GOAL_LINE);

    always_comb begin
        state_d = state_q;
        lives_d = lives_q;
        score_d = score_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        respawn = 1'b0;
        case (state_q)
            ATTRACT, GAME_OVER: begin
                if (tick && (keycode == KEY_ENTER)) begin
                    state_d = PLAY;
                    lives_d = LIVES_INIT;
                    score_d = '0;
                    level_d = '0;
                    respawn = 1'b1;
                end
            end
            PLAY: begin
                // Death outranks a goal on the same tick.
                if (tick && death) begin
                    state_d = DYING;
                    lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : lives_q;
                    cnt_d   = '0;
                end else if (tick && goal) begin
                    state_d = LEVEL_UP;
                    score_d = (&score_q) ? score_q : score_q + 1'b1;
                    level_d = (level_q >= LEVEL_TOP) ? level_q : level_q + 1'b1;
                    cnt_d   = '0;
                end
            end
            DYING: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        if (lives_q == 2'd0) begin
                            state_d = GAME_OVER;
                        end else begin
                            state_d = PLAY;
                            respawn = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            LEVEL_UP: begin
                if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = PLAY;
                        respawn = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ATTRACT;
        endcase
    end

    assign key_hop = key_to_hop(keycode);

    // An armed hop lives until the next tick; a key seen on a tick arms the following one.
    always_comb begin
        latch_d = latch_q;
        armed_d = tick ? HOP_NONE : armed_q;
        if (keycode == 16'd0) begin
            latch_d = 1'b0;
        end else if (!latch_q) begin
            latch_d = 1'b1;
            if (key_hop != HOP_NONE) begin
                armed_d = key_hop;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ATTRACT;
            lives_q <= LIVES_INIT;
            score_q <= '0;
            level_q <= '0;
            cnt_q   <= '0;
            latch_q <= 1'b0;
            armed_q <= HOP_NONE;
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
            score_q <= score_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            latch_q <= latch_d;
            armed_q <= armed_d;
        end
    end

    // All pulses are single-cycle and qualified by the frame tick; respawn masks hops.
    assign hop_fire     = tick && (state_q == PLAY) && !respawn;
    assign up           = hop_fire && (armed_q == HOP_UP);
    assign down         = hop_fire && (armed_q == HOP_DOWN);
    assign left         = hop_fire && (armed_q == HOP_LEFT);
    assign right        = hop_fire && (armed_q == HOP_RIGHT);
    assign Frog_Respawn = respawn;
    assign Game_Run     = (state_q == PLAY);
    assign Lives        = lives_q;
    assign Score        = score_q;
    assign Level        = level_q;
    assign State        = state_q;

endmodule

// File: tb/tb_frogger_game_ctrl.sv
// Bench for frogger_game_ctrl: frame-level game model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_frogger_game_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        frame_vs;
    logic [15:0] keycode;
    logic [3:0]  Car_Collision;
    logic [3:0]  LPad_Collision;
    logic        Frog_In_River;
    logic [10:0] Frog_Y;
    logic        up, down, left, right;
    logic        Frog_Respawn, Game_Run;
    logic [1:0]  Lives;
    logic [7:0]  Score;
    logic [2:0]  Level;
    logic [2:0]  State;
`ifdef FROGGER_TIMER_EN
    logic [7:0]  Time_Left;
`endif

    frogger_game_ctrl dut (
        .Clk            (Clk),
        .Reset_n        (Reset_n),
        .frame_vs       (frame_vs),
        .keycode        (keycode),
        .Car_Collision  (Car_Collision),
        .LPad_Collision (LPad_Collision),
        .Frog_In_River  (Frog_In_River),
        .Frog_Y         (Frog_Y),
        .up             (up),
        .down           (down),
        .left           (left),
        .right          (right),
        .Frog_Respawn   (Frog_Respawn),
        .Game_Run       (Game_Run),
        .Lives          (Lives),
        .Score          (Score),
        .Level          (Level),
        .State          (State)
`ifdef FROGGER_TIMER_EN
        , .Time_Left    (Time_Left)
`endif
    );

    // Clock and frame source: vsync low for 3 of every 10 cycles.
    always #5 Clk = ~Clk;

    int ph = 0;
    initial begin
        frame_vs = 1'b1;
        forever begin
            @(posedge Clk);
            #1;
            ph = (ph + 1) % 10;
            frame_vs = (ph >= 3);
        end
    end

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int tick_count = 0;
    int respawn_cnt = 0, up_cnt = 0, down_cnt = 0, left_cnt = 0, right_cnt = 0;

    // Game model: states 0 attract, 1 play, 2 dying, 3 level-up, 4 game over.
    int m_state = 0, m_lives = 3, m_score = 0, m_level = 0, m_wait = 0;
    int m_pend = 0, m_latch = 0, m_time = 0;
    bit h1 = 0, h2 = 0, h3 = 0, m_t = 0, e_rsp = 0, m_death = 0, m_timeout = 0;
    logic [3:0]  e_hop;
    logic [21:0] exp_v, act_v;

    task automatic model_reset();
        m_state = 0; m_lives = 3; m_score = 0; m_level = 0; m_wait = 0;
        m_pend = 0; m_latch = 0; m_time = 0;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        cyc++;
        if (!Reset_n) begin
            model_reset();
            h1 = 0; h2 = 0; h3 = 0; m_t = 0;
        end else begin
            // Tick lands two cycles after vsync is seen falling.
            m_t = h3 && !h2;
            h3 = h2; h2 = h1; h1 = frame_vs;
        end

        e_rsp = 0;
        e_hop = 4'b0000;
        if (m_t) begin
            if ((m_state == 0 || m_state == 4) && keycode == 16'h0028) e_rsp = 1;
            if (m_state == 2 && m_wait == 1 && m_lives > 0) e_rsp = 1;
            if (m_state == 3 && m_wait == 1) e_rsp = 1;
            if (m_state == 1 && !e_rsp) begin
                case (m_pend)
                    1: e_hop = 4'b1000;
                    2: e_hop = 4'b0100;
                    3: e_hop = 4'b0010;
                    4: e_hop = 4'b0001;
                    default: e_hop = 4'b0000;
                endcase
            end
        end
        exp_v = {e_hop, e_rsp, (m_state == 1), 2'(m_lives), 8'(m_score), 3'(m_level), 3'(m_state)};
        act_v = {up, down, left, right, Frog_Respawn, Game_Run, Lives, Score, Level, State};
        n_cmp++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs cycle %0d: got %h, expected %h", cyc, act_v, exp_v);
        end
`ifdef FROGGER_TIMER_EN
        check("time_left", int'(Time_Left), m_time);
`endif
        if (Frog_Respawn) respawn_cnt++;
        if (up) up_cnt++;
        if (down) down_cnt++;
        if (left) left_cnt++;
        if (right) right_cnt++;

        if (m_t) begin
            tick_count++;
            case (m_state)
                0, 4: if (keycode == 16'h0028) begin
                    m_state = 1; m_lives = 3; m_score = 0; m_level = 0; m_time = 200;
                end
                1: begin
                    if (m_time > 0) m_time--;
`ifdef FROGGER_TIMER_EN
                    m_timeout = (m_time == 0);
`else
                    m_timeout = 0;
`endif
                    m_death = (Car_Collision != 0) || (Frog_In_River && LPad_Collision == 0) || m_timeout;
                    if (m_death) begin
                        m_state = 2; m_lives--; m_wait = 60;
                    end else if (Frog_Y <= 40) begin
                        m_state = 3; m_wait = 60;
                        if (m_score < 255) m_score++;
                        if (m_level < 7) m_level++;
                    end
                end
                2, 3: begin
                    m_wait--;
                    if (m_wait == 0) begin
                        if (m_state == 2 && m_lives == 0) m_state = 4;
                        else begin m_state = 1; m_time = 200; end
                    end
                end
                default: m_state = 0;
            endcase
        end

        if (Reset_n) begin
            if (m_t) m_pend = 0;
            if (keycode == 16'h0000) m_latch = 0;
            else if (m_latch == 0) begin
                m_latch = 1;
                case (keycode)
                    16'h0052: m_pend = 1;
                    16'h0051: m_pend = 2;
                    16'h0050: m_pend = 3;
                    16'h004F: m_pend = 4;
                    default: ;
                endcase
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        int target;
        int guard;
        target = tick_count + n;
        guard = 0;
        while (tick_count < target && guard < 20 * n + 40) begin
            @(posedge Clk);
            guard++;
        end
        if (tick_count < target) begin
            n_cmp++;
            n_fail++;
            $display("FAIL tick_wait: got %0d ticks, expected %0d", tick_count, target);
        end
        #1;
    endtask

    task automatic tap_key(input logic [15:0] k);
        keycode = k;
        step(2);
        keycode = 16'h0000;
        wait_ticks(2);
    endtask

    int r0, u0, d0, l0, rt0;

    initial begin
        Reset_n = 1'b1;
        keycode = 16'h0000;
        Car_Collision = 4'd0;
        LPad_Collision = 4'd0;
        Frog_In_River = 1'b0;
        Frog_Y = 11'd400;
        #2 Reset_n = 1'b0;
        step(3);
        check("reset_state", State, 0);
        check("reset_lives", Lives, 3);
        check("reset_score", Score, 0);
        check("reset_level", Level, 0);
        check("reset_run", Game_Run, 0);
        Reset_n = 1'b1;
        step(4);

        keycode = 16'h0028;
        wait_ticks(2);
        keycode = 16'h0000;
        check("start_respawns", respawn_cnt, 1);
        check("start_state", State, 1);
        check("start_lives", Lives, 3);
        check("start_run", Game_Run, 1);
        step(2);

        u0 = up_cnt;
        keycode = 16'h0052;
        wait_ticks(10);
        keycode = 16'h0000;
        step(3);
        keycode = 16'h0052;
        wait_ticks(2);
        keycode = 16'h0000;
        step(2);
        check("held_up_pulses", up_cnt - u0, 2);

        l0 = left_cnt; rt0 = right_cnt; d0 = down_cnt;
        tap_key(16'h0050);
        check("left_pulse", left_cnt - l0, 1);
        tap_key(16'h004F);
        check("right_pulse", right_cnt - rt0, 1);
        tap_key(16'h0051);
        check("down_pulse", down_cnt - d0, 1);
        u0 = up_cnt;
        keycode = 16'h0004;
        step(2);
        keycode = 16'h0052;
        wait_ticks(2);
        keycode = 16'h0000;
        step(2);
        check("latched_no_hop", up_cnt - u0, 0);

        for (int i = 0; i < 3; i++) begin
            r0 = respawn_cnt;
            Car_Collision = 4'b0100;
            wait_ticks(1);
            Car_Collision = 4'd0;
            check("car_death_state", State, 2);
            check("car_death_lives", Lives, 2 - i);
            wait_ticks(59);
            check("dying_hold", State, 2);
            wait_ticks(1);
            if (i < 2) begin
                check("revive_state", State, 1);
                check("revive_respawn", respawn_cnt - r0, 1);
            end else begin
                check("over_state", State, 4);
                check("over_lives", Lives, 0);
                check("over_no_respawn", respawn_cnt - r0, 0);
            end
        end

        keycode = 16'h0028;
        wait_ticks(1);
        keycode = 16'h0000;
        check("restart_state", State, 1);
        check("restart_lives", Lives, 3);

        Frog_In_River = 1'b1;
        LPad_Collision = 4'b0010;
        wait_ticks(3);
        check("on_lilypad", State, 1);
        LPad_Collision = 4'd0;
        wait_ticks(1);
        Frog_In_River = 1'b0;
        check("drowned_state", State, 2);
        check("drowned_lives", Lives, 2);
        wait_ticks(60);
        check("drowned_revive", State, 1);

        Frog_Y = 11'd40;
        Car_Collision = 4'b0001;
        wait_ticks(1);
        Car_Collision = 4'd0;
        Frog_Y = 11'd400;
        check("death_beats_goal", State, 2);
        check("no_goal_score", Score, 0);
        wait_ticks(60);
        check("goal_tie_revive", State, 1);

        Frog_Y = 11'd41;
        wait_ticks(2);
        check("y41_no_goal", State, 1);
        Frog_Y = 11'd40;
        wait_ticks(1);
        Frog_Y = 11'd400;
        check("goal_state", State, 3);
        check("goal_score", Score, 1);
        check("goal_level", Level, 1);
        l0 = left_cnt;
        keycode = 16'h0050;
        step(2);
        keycode = 16'h0000;
        wait_ticks(60);
        check("goal_revive", State, 1);
        check("hop_dropped", left_cnt - l0, 0);

        for (int g = 0; g < 7; g++) begin
            Frog_Y = 11'd40;
            wait_ticks(1);
            Frog_Y = 11'd400;
            wait_ticks(60);
        end
        check("eight_goals_score", Score, 8);
        check("level_saturated", Level, 7);

        Car_Collision = 4'b0001;
        wait_ticks(1);
        Car_Collision = 4'd0;
        wait_ticks(5);
        check("pre_reset_dying", State, 2);
        Reset_n = 1'b0;
        #1;
        check("async_reset_state", State, 0);
        check("async_reset_lives", Lives, 3);
        check("async_reset_score", Score, 0);
        check("async_reset_level", Level, 0);
        step(3);
        Reset_n = 1'b1;
        step(5);
        check("post_reset_idle", State, 0);

`ifdef FROGGER_TIMER_EN
        keycode = 16'h0028;
        wait_ticks(1);
        keycode = 16'h0000;
        wait_ticks(199);
        check("timer_alive", State, 1);
        wait_ticks(1);
        check("timer_death", State, 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
